gray_code_generator: RTL and testbench
======================================

# gray_code_generator

Sequential Gray-code source for the board demo: it holds a WIDTH-bit binary counter, steps it up or down from a debounced push-button or a free-running prescaler, and drives the registered Gray encoding of the count. It is the encoder end of the Gray-to-binary path, and its `codigo_gray_po` feeds the existing Gray decoder, LED and 7-segment chain in place of the slide switches. A one-cycle `valido_po` strobe marks every new code word.

## Interface
Parameters:
- `WIDTH`, default 4: code width in bits.
- `DIV_CNT`, default 27_000_000: prescaler period in clocks for auto mode (1 Hz at 27 MHz). Minimum 2.
- `DEBOUNCE_CNT`, default 270_000: clocks the button must be stable before it is accepted (10 ms). Minimum 1.

Ports:
- `clk_pi`, input, 1: system clock. All logic uses its rising edge.
- `rst_n_pi`, input, 1: reset. Asynchronous, active-low.
- `boton_paso_pi`, input, 1: raw step button, active-high, asynchronous to `clk_pi`.
- `modo_auto_pi`, input, 1: 1 = prescaler steps the counter; 0 = button steps it.
- `dir_pi`, input, 1: 1 = count up; 0 = count down.
- `carga_pi`, input, 1: synchronous load strobe, sampled each clock.
- `valor_bin_pi`, input, WIDTH: binary value loaded when `carga_pi` = 1.
- `codigo_gray_po`, output, WIDTH: registered Gray code of the count.
- `codigo_bin_po`, output, WIDTH: registered binary count, for checking.
- `valido_po`, output, 1: one-cycle pulse in the cycle the outputs take a new value.
- `envuelta_po`, output, 1: one-cycle pulse that coincides with `valido_po` on a wrap-around.

## Operation
- **Gray encoding.** `codigo_gray_po` = `codigo_bin_po` XOR (`codigo_bin_po` >> 1). Both outputs are registered from the same next-count value, so they never disagree.
- **Button path.**
  - Two-flop synchronizer on `boton_paso_pi`.
  - Debouncer: a counter clears whenever the synchronized value equals the debounced state. Otherwise it increments.
  - When the counter is at DEBOUNCE_CNT-1 and the values still differ, the debounced state takes the synchronized value.
  - A rising edge of the debounced state gives one step pulse. Falling edges and held levels give nothing.
- **Prescaler.**
  - While `modo_auto_pi` = 1, it counts 0..DIV_CNT-1 and wraps. The terminal count gives a one-cycle tick.
  - While `modo_auto_pi` = 0, it is held at 0.
- **Step source.** Step event = tick when `modo_auto_pi` = 1, and the button pulse when `modo_auto_pi` = 0. In auto mode the button is debounced but ignored.
- **Priority, highest first:**
  1. Load: count takes `valor_bin_pi`, `valido_po` pulses, the prescaler clears to 0, and `envuelta_po` stays 0.
  2. Step event: count +1 if `dir_pi` = 1, −1 if `dir_pi` = 0, modulo 2^WIDTH.
  3. Otherwise the count holds and both strobes are 0.
- **Wrap.** Up from 2^WIDTH−1 to 0, or down from 0 to 2^WIDTH−1, asserts `envuelta_po`.
- **Same value.** Loading the current value still pulses `valido_po`.

## Timing
- **Reset.** While `rst_n_pi` = 0, every register clears immediately: count, `codigo_gray_po` = 0, `codigo_bin_po` = 0, `valido_po` = 0, `envuelta_po` = 0, prescaler = 0, synchronizer = 0, debounce counter = 0, debounced state = 0. Asserting reset mid-step abandons the step. After release, the first step event is counted from the cleared state.
- **Load and tick latency.** A load or tick in cycle N gives new outputs and the strobes after the rising edge ending cycle N. The strobes are high for exactly that one cycle.
- **Button latency.** A raw button rise before edge 0, held stable, updates the outputs at rising edge DEBOUNCE_CNT+3. That is 2 edges of synchronizer, DEBOUNCE_CNT of debounce, and 1 of edge detection into the count register.
- **Glitches.** A raw pulse shorter than DEBOUNCE_CNT clocks after synchronization produces no step.
- **Auto period.** The first tick comes DIV_CNT cycles after `modo_auto_pi` rises. Ticks then repeat every DIV_CNT cycles. A load restarts this spacing.
- **Direction.** `dir_pi` is sampled in the step cycle only. Changing it between steps has no other effect.
- **Mode change.** Switching auto→manual with the button held gives no step, because no rising edge occurs.
- **Simultaneous events.** A load together with a tick or button pulse loads, and the step is dropped.

## Test plan
Bench parameters: DEBOUNCE_CNT = 4, DIV_CNT = 5.
- **Reset.** Assert `rst_n_pi` = 0 mid-count at bin 0111 → gray, bin and both strobes are 0 before the next clock edge. Release, then give one up step → bin 0001, gray 0001.
- **Manual up sweep.** 16 clean presses with `dir_pi` = 1 from 0 → gray 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000. The 16th press asserts `envuelta_po` with `valido_po`. Each update lands exactly 7 edges after the raw rise.
- **Bounce.** Three 2-cycle pulses, then a held press → exactly one step, with one `valido_po` pulse.
- **Auto down.** `modo_auto_pi` = 1, `dir_pi` = 0, from 0 → first tick after 5 cycles gives bin 1111, gray 1000, and `envuelta_po` = 1. Then one `valido_po` every 5 cycles: bin 1110, 1101, …
- **Load priority.** Load 1010 in the same cycle as a tick → bin 1010, gray 1111, `envuelta_po` = 0. The next tick comes 5 cycles later and gives bin 1011.

Source files
------------

// File: rtl/gray_code_generator.sv
// Gray-code source: a binary counter stepped by a debounced button or a prescaler tick,
// with registered binary/Gray outputs and valid/wrap strobes.
module gray_code_generator #(
   parameter int WIDTH        = 4,
   parameter int DIV_CNT      = 27_000_000,
   parameter int DEBOUNCE_CNT = 270_000
) (
   input  logic             clk_pi,
   input  logic             rst_n_pi,
   input  logic             boton_paso_pi,
   input  logic             modo_auto_pi,
   input  logic             dir_pi,
   input  logic             carga_pi,
   input  logic [WIDTH-1:0] valor_bin_pi,
   output logic [WIDTH-1:0] codigo_gray_po,
   output logic [WIDTH-1:0] codigo_bin_po,
   output logic             valido_po,
   output logic             envuelta_po
);

   localparam int DBW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
   localparam int PW  = $clog2(DIV_CNT);

   logic [1:0]       sync_q;
   logic [DBW-1:0]   db_cnt_q;
   logic             db_q;
   logic             db_prev_q;
   logic             btn_pulse;
   logic [PW-1:0]    pre_q;
   logic             tick;
   logic             step;
   logic [WIDTH-1:0] bin_q;
   logic [WIDTH-1:0] bin_nxt;
   logic             vld_nxt;
   logic             env_nxt;

   // Button: two-flop synchronizer, then a stability counter that must reach
   // DEBOUNCE_CNT-1 with the input still differing before the state flips.
   always_ff @(posedge clk_pi or negedge rst_n_pi) begin
      if (!rst_n_pi) begin
         sync_q    <= '0;
         db_cnt_q  <= '0;
         db_q      <= 1'b0;
         db_prev_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], boton_paso_pi};
         db_prev_q <= db_q;
         if (sync_q[1] == db_q) begin
            db_cnt_q <= '0;
         end else if (db_cnt_q == DBW'(DEBOUNCE_CNT - 1)) begin
            db_cnt_q <= '0;
            db_q     <= sync_q[1];
         end else begin
            db_cnt_q <= db_cnt_q + DBW'(1);
         end
      end
   end

   assign btn_pulse = db_q & ~db_prev_q;

   // A load restarts the tick spacing, so it clears the prescaler as well.
   always_ff @(posedge clk_pi or negedge rst_n_pi) begin
      if (!rst_n_pi) begin
         pre_q <= '0;
      end else if (!modo_auto_pi || carga_pi) begin
         pre_q <= '0;
      end else if (pre_q == PW'(DIV_CNT - 1)) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_q + PW'(1);
      end
   end

   assign tick = modo_auto_pi && (pre_q == PW'(DIV_CNT - 1));
   assign step = modo_auto_pi ? tick : btn_pulse;

   always_comb begin
      bin_nxt = bin_q;
      vld_nxt = 1'b0;
      env_nxt = 1'b0;
      if (carga_pi) begin
         bin_nxt = valor_bin_pi;
         vld_nxt = 1'b1;
      end else if (step) begin
         vld_nxt = 1'b1;
         if (dir_pi) begin
            bin_nxt = bin_q + WIDTH'(1);
            env_nxt = &bin_q;
         end else begin
            bin_nxt = bin_q - WIDTH'(1);
            env_nxt = ~|bin_q;
         end
      end
   end

   // Both code outputs come from bin_nxt so they always describe the same count.
   always_ff @(posedge clk_pi or negedge rst_n_pi) begin
      if (!rst_n_pi) begin
         bin_q          <= '0;
         codigo_bin_po  <= '0;
         codigo_gray_po <= '0;
         valido_po      <= 1'b0;
         envuelta_po    <= 1'b0;
      end else begin
         bin_q          <= bin_nxt;
         codigo_bin_po  <= bin_nxt;
         codigo_gray_po <= bin_nxt ^ (bin_nxt >> 1);
         valido_po      <= vld_nxt;
         envuelta_po    <= env_nxt;
      end
   end

endmodule

// File: tb/tb_gray_code_generator.sv
// Directed bench for gray_code_generator: reset, manual sweep with latency, bounce,
// auto down-count and load-over-tick priority, with DEBOUNCE_CNT=4 and DIV_CNT=5.
module tb_gray_code_generator;

   logic       clk_pi = 1'b0;
   logic       rst_n_pi;
   logic       boton_paso_pi;
   logic       modo_auto_pi;
   logic       dir_pi;
   logic       carga_pi;
   logic [3:0] valor_bin_pi;
   logic [3:0] codigo_gray_po;
   logic [3:0] codigo_bin_po;
   logic       valido_po;
   logic       envuelta_po;

   int total = 0;
   int bad   = 0;

   gray_code_generator #(.WIDTH(4), .DIV_CNT(5), .DEBOUNCE_CNT(4)) dut (
      .clk_pi         (clk_pi),
      .rst_n_pi       (rst_n_pi),
      .boton_paso_pi  (boton_paso_pi),
      .modo_auto_pi   (modo_auto_pi),
      .dir_pi         (dir_pi),
      .carga_pi       (carga_pi),
      .valor_bin_pi   (valor_bin_pi),
      .codigo_gray_po (codigo_gray_po),
      .codigo_bin_po  (codigo_bin_po),
      .valido_po      (valido_po),
      .envuelta_po    (envuelta_po)
   );

   always #5 clk_pi = ~clk_pi;

   task automatic step();
      @(posedge clk_pi);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] eb, input logic [3:0] eg,
                          input logic ev, input logic ee);
      chk({tag, "_bin"},  codigo_bin_po,  eb);
      chk({tag, "_gray"}, codigo_gray_po, eg);
      chk({tag, "_vld"},  valido_po,      ev);
      chk({tag, "_env"},  envuelta_po,    ee);
   endtask

   // Raw rise right after an edge must update the outputs on the 7th edge after it.
   task automatic press(input string tag, input logic [3:0] eb, input logic [3:0] eg,
                        input logic ee);
      int early;
      early = 0;
      boton_paso_pi = 1'b1;
      repeat (6) begin
         step();
         if (valido_po) early++;
      end
      step();
      chk({tag, "_early"}, early, 0);
      chk_out(tag, eb, eg, 1'b1, ee);
      step();
      chk({tag, "_vld_drop"}, valido_po, 1'b0);
      boton_paso_pi = 1'b0;
      early = 0;
      repeat (8) begin
         step();
         if (valido_po) early++;
      end
      chk({tag, "_release"}, early, 0);
   endtask

   // Auto mode: four silent edges, then the fifth edge carries the update.
   task automatic auto_tick(input string tag, input logic [3:0] eb, input logic [3:0] eg,
                            input logic ee);
      int early;
      early = 0;
      repeat (4) begin
         step();
         if (valido_po) early++;
      end
      step();
      chk({tag, "_early"}, early, 0);
      chk_out(tag, eb, eg, 1'b1, ee);
   endtask

   logic [3:0] gray_tbl [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
                                 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                 4'b1011, 4'b1001, 4'b1000, 4'b0000};

   initial begin
      int cnt;
      rst_n_pi      = 1'b0;
      boton_paso_pi = 1'b0;
      modo_auto_pi  = 1'b0;
      dir_pi        = 1'b1;
      carga_pi      = 1'b0;
      valor_bin_pi  = 4'd0;

      repeat (3) step();
      chk_out("reset", 4'h0, 4'h0, 1'b0, 1'b0);
      rst_n_pi = 1'b1;
      step();

      // Load 0111, then assert reset between edges
      carga_pi     = 1'b1;
      valor_bin_pi = 4'b0111;
      step();
      carga_pi = 1'b0;
      chk_out("load7", 4'b0111, 4'b0100, 1'b1, 1'b0);
      step();
      chk("load7_vld_drop", valido_po, 1'b0);
      rst_n_pi = 1'b0;
      #2;
      chk_out("async_rst", 4'h0, 4'h0, 1'b0, 1'b0);
      step();
      rst_n_pi = 1'b1;
      step();
      press("post_rst", 4'b0001, 4'b0001, 1'b0);

      // Manual up sweep from 0
      carga_pi     = 1'b1;
      valor_bin_pi = 4'd0;
      step();
      carga_pi = 1'b0;
      chk_out("load0", 4'h0, 4'h0, 1'b1, 1'b0);
      step();
      for (int i = 0; i < 16; i++) begin
         press($sformatf("sweep%0d", i), 4'(i + 1), gray_tbl[i], (i == 15));
      end

      // Bounce: three 2-cycle glitches then a held press gives exactly one step
      cnt = 0;
      for (int k = 0; k < 3; k++) begin
         boton_paso_pi = 1'b1;
         repeat (2) begin step(); if (valido_po) cnt++; end
         boton_paso_pi = 1'b0;
         repeat (2) begin step(); if (valido_po) cnt++; end
      end
      boton_paso_pi = 1'b1;
      repeat (12) begin step(); if (valido_po) cnt++; end
      chk("bounce_pulses", cnt, 1);
      chk("bounce_bin",  codigo_bin_po,  4'b0001);
      chk("bounce_gray", codigo_gray_po, 4'b0001);
      boton_paso_pi = 1'b0;
      repeat (8) step();

      // Auto down from 0
      carga_pi     = 1'b1;
      valor_bin_pi = 4'd0;
      step();
      carga_pi = 1'b0;
      chk_out("load0b", 4'h0, 4'h0, 1'b1, 1'b0);
      modo_auto_pi = 1'b1;
      dir_pi       = 1'b0;
      auto_tick("auto1", 4'b1111, 4'b1000, 1'b1);
      auto_tick("auto2", 4'b1110, 4'b1001, 1'b0);
      auto_tick("auto3", 4'b1101, 4'b1011, 1'b0);

      // Load coincident with the next tick wins; spacing restarts from the load
      repeat (4) step();
      chk("pre_load_vld", valido_po, 1'b0);
      carga_pi     = 1'b1;
      valor_bin_pi = 4'b1010;
      dir_pi       = 1'b1;
      step();
      carga_pi = 1'b0;
      chk_out("load_prio", 4'b1010, 4'b1111, 1'b1, 1'b0);
      auto_tick("after_load", 4'b1011, 4'b1110, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
